// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
package loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and imem write port of the program loader.
// Handshake: a byte moves on every rising clk edge where s_valid && s_ready;
// the source holds s_data stable and keeps s_valid high until that edge, and
// s_ready never depends on s_valid. imem_we is a one-cycle write strobe that
// qualifies imem_addr/imem_wdata; there is no back-pressure on the write side.
interface prog_loader_if #(
    parameter int IMEM_AW = 10
);
    logic [7:0]         s_data;
    logic               s_valid;
    logic               s_ready;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_wdata;

    // Byte source plus imem observer side.
    modport master (
        output s_data, s_valid,
        input  s_ready, imem_we, imem_addr, imem_wdata
    );

    // Loader side.
    modport slave (
        input  s_data, s_valid,
        output s_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// Little-endian byte-to-word assembler. The first byte of a word lands in
// bits [7:0]; word/word_valid are combinational on the 4th byte so the
// caller can register them into its write stage without a bubble.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);
    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  byte_idx;
    logic [23:0] lower_q;

    // Byte index and the three lower bytes of the word being assembled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx <= 2'd0;
            lower_q  <= 24'd0;
        end else if (clear) begin
            byte_idx <= 2'd0;
            lower_q  <= 24'd0;
        end else if (byte_en) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
                2'd0:    lower_q[7:0]   <= byte_data;
                2'd1:    lower_q[15:8]  <= byte_data;
                2'd2:    lower_q[23:16] <= byte_data;
                default: lower_q        <= lower_q;
            endcase
        end
    end

    assign word_valid = byte_en && (byte_idx == LAST_IDX);
    assign word       = {byte_data, lower_q};

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: receives "N lo, N hi, N*4 data bytes [, xor]"
// and writes N words to imem from address 0, holding the CPU in reset
// until the load has succeeded.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CHK state).
module prog_loader
    import loader_pkg::*;
#(
    parameter int IMEM_AW = 10,
    parameter int INST_W  = 32
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    prog_loader_if.slave     bus,
    output logic             cpu_rst,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IMEM_AW:0] words_loaded,
    output state_t           dbg_state
);
    localparam logic [16:0] DEPTH = 17'(2 ** IMEM_AW);
`ifdef LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = S_CHK;
`else
    localparam state_t AFTER_DATA = S_DONE;
`endif

    state_t              state, state_next;
    logic                accept, clear, last_write;
    logic                hdr_idx;
    logic [7:0]          n_lo;
    logic [15:0]         n_hdr;
    logic [IMEM_AW:0]    n_words;
    logic                word_valid;
    logic [INST_W-1:0]   word;
    logic                imem_we_q;
    logic [IMEM_AW-1:0]  addr_q;
    logic [INST_W-1:0]   wdata_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          csum;
`endif

    assign accept     = bus.s_valid && bus.s_ready;
    assign n_hdr      = {bus.s_data, n_lo};
    // The final word's write cycle: stop taking bytes and leave DATA after it.
    assign last_write = imem_we_q && (words_loaded == n_words);

    // Next-state and Moore status outputs.
    always_comb begin
        state_next  = state;
        bus.s_ready = 1'b0;
        busy        = 1'b0;
        cpu_rst     = 1'b1;
        done        = 1'b0;
        error       = 1'b0;
        clear       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_HDR;
                    clear      = 1'b1;
                end
            end
            S_HDR: begin
                bus.s_ready = 1'b1;
                busy        = 1'b1;
                if (accept && hdr_idx) begin
                    if ({1'b0, n_hdr} > DEPTH) state_next = S_ERR;
                    else if (n_hdr == 16'd0)   state_next = AFTER_DATA;
                    else                       state_next = S_DATA;
                end
            end
            S_DATA: begin
                bus.s_ready = !last_write;
                busy        = 1'b1;
                if (last_write) state_next = AFTER_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                bus.s_ready = 1'b1;
                busy        = 1'b1;
                if (accept) state_next = (bus.s_data == csum) ? S_DONE : S_ERR;
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b0;
                if (start) begin
                    state_next = S_HDR;
                    clear      = 1'b1;
                end
            end
            S_ERR: begin
                error = 1'b1;
                if (start) begin
                    state_next = S_HDR;
                    clear      = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    assign dbg_state = state;

    // Header capture: low byte first, then latch the word count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr_idx <= 1'b0;
            n_lo    <= 8'd0;
            n_words <= '0;
        end else if (clear) begin
            hdr_idx <= 1'b0;
        end else if (state == S_HDR && accept) begin
            hdr_idx <= ~hdr_idx;
            if (!hdr_idx) n_lo    <= bus.s_data;
            else          n_words <= n_hdr[IMEM_AW:0];
        end
    end

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .byte_en    (accept && (state == S_DATA)),
        .byte_data  (bus.s_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Registered write stage; the count steps on the edge that raises imem_we.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_we_q    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            words_loaded <= '0;
        end else begin
            imem_we_q <= word_valid;
            if (clear) begin
                words_loaded <= '0;
            end else if (word_valid) begin
                addr_q       <= words_loaded[IMEM_AW-1:0];
                wdata_q      <= word;
                words_loaded <= words_loaded + (IMEM_AW+1)'(1);
            end
        end
    end

    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

`ifdef LOADER_CHECKSUM_EN
    // Running XOR over every accepted header and data byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                             csum <= 8'd0;
        else if (clear)                                       csum <= 8'd0;
        else if (accept && (state == S_HDR || state == S_DATA)) csum <= csum ^ bus.s_data;
    end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: byte driver, imem write scoreboard with a
// separate monitor, and status checks after each load.
// Honours LOADER_CHECKSUM_EN to append/corrupt the trailing checksum byte.
module tb_prog_loader;
    import loader_pkg::*;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         cpu_rst, busy, done, error;
    logic [AW:0]  words_loaded;
    state_t       dbg_state;

    prog_loader_if #(.IMEM_AW(AW)) bus();

    prog_loader #(.IMEM_AW(AW), .INST_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded),
        .dbg_state    (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [AW+31:0] exp_q[$];   // {addr, data}
    logic [7:0]     stim[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every imem write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst && bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", bus.imem_addr, bus.imem_wdata);
            end else begin
                logic [AW+31:0] e;
                e = exp_q.pop_front();
                check("imem_addr", bus.imem_addr, e[AW+31:32]);
                check("imem_wdata", bus.imem_wdata, e[31:0]);
                check("cpu_rst_during_write", cpu_rst, 1'b1);
                check("done_during_write", done, 1'b0);
            end
        end
    end

    function automatic logic [7:0] stim_xor();
        logic [7:0] x = 8'd0;
        foreach (stim[i]) x ^= stim[i];
        return x;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int cnt = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        while (!bus.s_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL s_ready_timeout: got s_ready 0 expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1 bus.s_valid = 1'b0;
    endtask

    task automatic send_stim(input int gap);
        foreach (stim[i]) send_byte(stim[i], gap);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        int cnt = 0;
        while (!(done || error) && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL end_timeout: got no done/error expected one within 200 cycles");
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_done(input string tag, input int wl);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_error"}, error, 1'b0);
        check({tag, "_cpu_rst"}, cpu_rst, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_s_ready"}, bus.s_ready, 1'b0);
        check({tag, "_words_loaded"}, words_loaded, wl);
        check({tag, "_state"}, dbg_state, S_DONE);
        check({tag, "_pending_writes"}, exp_q.size(), 0);
    endtask

    task automatic check_err(input string tag);
        check({tag, "_error"}, error, 1'b1);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_cpu_rst"}, cpu_rst, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_s_ready"}, bus.s_ready, 1'b0);
        check({tag, "_state"}, dbg_state, S_ERR);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_s_ready"}, bus.s_ready, 1'b0);
        check({tag, "_imem_we"}, bus.imem_we, 1'b0);
        check({tag, "_imem_addr"}, bus.imem_addr, 0);
        check({tag, "_imem_wdata"}, bus.imem_wdata, 0);
        check({tag, "_cpu_rst"}, cpu_rst, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_error"}, error, 1'b0);
        check({tag, "_words_loaded"}, words_loaded, 0);
        check({tag, "_state"}, dbg_state, S_IDLE);
    endtask

    task automatic load_three_word_stim();
        stim = '{8'h03, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00, 8'h33, 8'h01, 8'h21, 8'h00};
        exp_q.push_back({10'd0, 32'h0000_0013});
        exp_q.push_back({10'd1, 32'h0010_0093});
        exp_q.push_back({10'd2, 32'h0021_0133});
    endtask

    // Stimulus sequence.
    initial begin
        bus.s_data  = 8'h00;
        bus.s_valid = 1'b0;

        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b1;

        // Three-word program, back-to-back bytes.
        load_three_word_stim();
`ifdef LOADER_CHECKSUM_EN
        check("stream_checksum", stim_xor(), 8'h80);
        stim.push_back(8'h80);
`endif
        pulse_start();
        send_stim(0);
        wait_end();
        check_done("three_words", 3);

        // Bytes offered after the load must not be taken.
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hFF;
        repeat (3) @(negedge clk);
        check("extra_byte_s_ready", bus.s_ready, 1'b0);
        check("extra_byte_words_loaded", words_loaded, 3);
        bus.s_valid = 1'b0;

        // Same stream with s_valid low every other cycle; a start mid-load is ignored.
        load_three_word_stim();
`ifdef LOADER_CHECKSUM_EN
        stim.push_back(8'h80);
`endif
        pulse_start();
        check("restart_cpu_rst", cpu_rst, 1'b1);
        for (int i = 0; i < stim.size(); i++) begin
            send_byte(stim[i], 1);
            if (i == 5) begin
                pulse_start();
                check("start_while_busy_state", dbg_state, S_DATA);
            end
        end
        wait_end();
        check_done("gapped", 3);

        // Empty program.
        stim = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        stim.push_back(8'h00);
`endif
        pulse_start();
        send_stim(0);
        wait_end();
        check_done("empty", 0);

        // Oversized header: DEPTH + 1 words.
        stim = '{8'h01, 8'h04};
        pulse_start();
        send_stim(0);
        wait_end();
        check_err("oversize");
        check("oversize_words_loaded", words_loaded, 0);

        // Full-capacity program: DEPTH words, addresses 0..DEPTH-1.
        stim.delete();
        stim.push_back(8'h00);
        stim.push_back(8'h04);
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] w;
            w = 32'hC0DE_0000 ^ (i * 32'h0001_0003);
            stim.push_back(w[7:0]);
            stim.push_back(w[15:8]);
            stim.push_back(w[23:16]);
            stim.push_back(w[31:24]);
            exp_q.push_back({10'(i), w});
        end
`ifdef LOADER_CHECKSUM_EN
        stim.push_back(stim_xor());
`endif
        pulse_start();
        send_stim(0);
        wait_end();
        check_done("full_depth", DEPTH);

`ifdef LOADER_CHECKSUM_EN
        // Corrupted checksum, then a clean retry.
        load_three_word_stim();
        stim.push_back(8'h80 ^ 8'h01);
        pulse_start();
        send_stim(0);
        wait_end();
        check_err("bad_checksum");
        load_three_word_stim();
        stim.push_back(8'h80);
        pulse_start();
        send_stim(0);
        wait_end();
        check_done("checksum_retry", 3);
`endif

        // Asynchronous reset after 5 bytes of a load.
        stim = '{8'h03, 8'h00, 8'h13, 8'h00, 8'h00};
        pulse_start();
        send_stim(0);
        #2 rst = 1'b0;
        #1;
        check_reset_values("mid_reset");
        @(negedge clk);
        rst = 1'b1;

        // One-word load after the abort.
        stim = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        exp_q.push_back({10'd0, 32'hDEAD_BEEF});
`ifdef LOADER_CHECKSUM_EN
        stim.push_back(8'h23);
`endif
        pulse_start();
        send_stim(0);
        wait_end();
        check_done("after_reset", 1);

        check("final_pending_writes", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
